// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: the op_code values decoded by the
// control unit, the divider's one-hot state encoding and the default datapath
// width.
//
// Configuration macro: DIVIDER_SIGNED_EN adds the SIGN_FIX state to the
// divider state set (two's-complement operation).
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_code_t;

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_RUN      = 4'b0010,
    ST_SIGN_FIX = 4'b0100,
    ST_DONE     = 4'b1000
  } div_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } div_state_t;
`endif

endpackage : alu_pkg

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The partial remainder is
// shifted left with the next dividend bit, the divisor is trial-subtracted in
// WIDTH+1 bits, and the subtraction is kept only if it did not go negative.
//
// Ports:
//   rem      in  WIDTH  current partial remainder (always < divisor)
//   bit_in   in  1      next dividend bit, MSB first
//   divisor  in  WIDTH  divisor (nonzero while iterating)
//   rem_out  out WIDTH  next partial remainder
//   q_bit    out 1      quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Because rem < divisor, shifted < 2*divisor: the MSB of the WIDTH+1-bit
  // difference is set exactly when the subtraction underflowed, and the kept
  // value (either branch) always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/restoring_divider.sv
// ----------------------------------------------------------------------------
// restoring_divider
// Sequential restoring divider answering the control unit's
// divider_start / divider_done handshake. One quotient bit per clock.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (aborts silently)
//   start        in   one-cycle request, sampled only while idle
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   quotient     out  WIDTH  registered result
//   remainder    out  WIDTH  registered result
//   done         out  one-cycle completion pulse
//   busy         out  high whenever not idle
//   div_by_zero  out  set for a zero divisor, held until next accepted start
//
// Configuration macro: DIVIDER_SIGNED_EN -- two's-complement operands,
// magnitudes divided, signs restored in an extra SIGN_FIX cycle.
// ----------------------------------------------------------------------------
module restoring_divider
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  div_state_t       state_reg, state_next;
  logic [WIDTH-1:0] rem_reg;        // partial remainder
  logic [WIDTH-1:0] q_reg;          // dividend bits shift out, quotient bits in
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             divisor_zero;
  logic             last_iter;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_reg;
  logic neg_r_reg;

  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is the correct magnitude 2^(WIDTH-1).
  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? (~dividend) + WIDTH'(1) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor)  + WIDTH'(1) : divisor;
  end
`else
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
  end
`endif

  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt_reg == CNT_W'(1));

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem    (rem_reg),
    .bit_in (q_reg[WIDTH-1]),
    .divisor(divisor_reg),
    .rem_out(step_rem),
    .q_bit  (step_bit)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = divisor_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
`ifdef DIVIDER_SIGNED_EN
          state_next = ST_SIGN_FIX;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      ST_SIGN_FIX: state_next = ST_DONE;
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rem_reg       <= '0;
      q_reg         <= '0;
      divisor_reg   <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            divisor_reg <= divisor_mag;
            if (divisor_zero) begin
              // Results are final immediately; raw dividend, no sign fixing.
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= dividend;
            end else begin
              dbz_reg <= 1'b0;
              rem_reg <= '0;
              q_reg   <= dividend_mag;
              cnt_reg <= CNT_W'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
              neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r_reg <= dividend[WIDTH-1];
`endif
            end
          end
        end
        ST_RUN: begin
          rem_reg <= step_rem;
          q_reg   <= {q_reg[WIDTH-2:0], step_bit};
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (last_iter) begin
            quotient_reg  <= {q_reg[WIDTH-2:0], step_bit};
            remainder_reg <= step_rem;
          end
        end
`ifdef DIVIDER_SIGNED_EN
        ST_SIGN_FIX: begin
          if (neg_q_reg) begin
            quotient_reg <= (~quotient_reg) + WIDTH'(1);
          end
          if (neg_r_reg) begin
            remainder_reg <= (~remainder_reg) + WIDTH'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign done        = (state_reg == ST_DONE);
  assign busy        = (state_reg != ST_IDLE);

endmodule : restoring_divider
